// File: rtl/motor_share_sched_pkg.sv
// Shared types and defaults for the motor-share scheduler. The state encoding
// is the one the existing motor FSM also uses.
package motor_share_sched_pkg;

    localparam int N_DEF  = 4;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/motor_share_sched_if.sv
// Request/length inputs and motor/indicator outputs of the motor-share scheduler.
// master = request logic side, slave = scheduler side.
interface motor_share_sched_if #(
    parameter int N  = 4,
    parameter int DW = 16
);
    logic [N-1:0]  req;
    logic [DW-1:0] run_len;
    logic [DW-1:0] hold_len;
    logic          abort;
    logic [N-1:0]  grant;
    logic          signal_main_motor;
    logic [N-1:0]  signal_motor;
    logic          done;
    logic          green_led;
    logic          red_led;

    modport master (
        output req, run_len, hold_len, abort,
        input  grant, signal_main_motor, signal_motor, done, green_led, red_led
    );

    modport slave (
        input  req, run_len, hold_len, abort,
        output grant, signal_main_motor, signal_motor, done, green_led, red_led
    );
endinterface

// File: rtl/motor_dly_timer.sv
// Load/decrement delay counter; a load of len yields max(len,1) cycles until zero.
// zero is a flag on the current count; load has priority over dec.
module motor_dly_timer #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          dec,
    input  logic [DW-1:0] len,
    output logic          zero
);
    logic [DW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= (len == '0) ? '0 : len - DW'(1);
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - DW'(1);
        end
    end

    assign zero = (count_q == '0);
endmodule

// File: rtl/motor_share_sched.sv
// Round-robin owner of the shared main motor: RUN (main+selected), HOLD (selected), DONE pulse.
// Early stop on abort is built only when MOTOR_SHARE_SCHED_ABORT_EN is defined.
module motor_share_sched
    import motor_share_sched_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    motor_share_sched_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, win_q, pick;
    logic [DW-1:0] hold_q, tmr_len;
    logic          tmr_load, tmr_dec, tmr_zero, abort_hit;
    logic [N-1:0]  grant_q;
    logic          main_q, done_q, busy_q;

    // First requester at or after the pointer, wrapping; scanning downwards
    // lets the smallest offset overwrite the result last.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] res;
        logic [IW-1:0] k;
        res = p;
        for (int i = N - 1; i >= 0; i--) begin
            k = IW'((int'(p) + i) % N);
            if (r[k]) res = k;
        end
        return res;
    endfunction

    assign pick = rr_pick(bus.req, ptr_q);

`ifdef MOTOR_SHARE_SCHED_ABORT_EN
    assign abort_hit = bus.abort;
`else
    logic unused_abort;
    assign abort_hit    = 1'b0;
    assign unused_abort = bus.abort;
`endif

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_len  = bus.run_len;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_d  = ST_RUN;
                    tmr_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (tmr_zero || abort_hit) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_len  = hold_q;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                if (tmr_zero) state_d = ST_DONE;
                else          tmr_dec = 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Output registers follow the transitions chosen above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            win_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            main_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            busy_q <= (state_d != ST_IDLE);
            done_q <= (state_q == ST_HOLD) && (state_d == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (state_d == ST_RUN) begin
                        win_q   <= pick;
                        hold_q  <= bus.hold_len;
                        grant_q <= N'(1) << pick;
                        main_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (state_d == ST_HOLD) main_q <= 1'b0;
                end
                ST_HOLD: begin
                    if (state_d == ST_DONE) begin
                        grant_q <= '0;
                        ptr_q   <= (win_q == IW'(N - 1)) ? '0 : win_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    motor_dly_timer #(.DW(DW)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (tmr_load),
        .dec  (tmr_dec),
        .len  (tmr_len),
        .zero (tmr_zero)
    );

    assign bus.grant             = grant_q;
    assign bus.signal_motor      = grant_q;
    assign bus.signal_main_motor = main_q;
    assign bus.done              = done_q;
    assign bus.green_led         = busy_q;
    assign bus.red_led           = ~busy_q;
endmodule
